// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, decode-stage stall and branch redirect.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise fetch_misalign and park fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] redirect_tgt;
  logic        tgt_misaligned;
  logic        redirect_take;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_tgt   = redirect_pc;
  assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
`else
  assign redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;
  assign tgt_misaligned = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // Once parked on a misaligned target, further redirects are ignored until reset.
  assign redirect_take = redirect && !misalign_q;

  // Next-state process.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
    state_d    = state_q;
    pc_next_d  = pc_next_q;
    req_addr_d = req_addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    case (state_q)
      FETCH: begin
        req_addr_d = pc_next_q;
        if (imem_ack && !redirect_take) begin
          instr_d = imem_rdata;
          pc_d    = pc_next_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (imem_ack) begin
          state_d = FETCH;
        end else begin
          state_d = redirect_take ? FLUSH : WAIT;
        end
      end
      WAIT: begin
        if (imem_ack && !redirect_take) begin
          instr_d = imem_rdata;
          pc_d    = req_addr_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (imem_ack) begin
          state_d = FETCH;
        end else if (redirect_take) begin
          state_d = FLUSH;
        end
      end
      HOLD: begin
        if (redirect_take) begin
          state_d = FETCH;
        end else if (!stall && !misalign_q) begin
          pc_next_d = pc_q + 32'd4;
          valid_d   = 1'b0;
          state_d   = FETCH;
        end
      end
      FLUSH: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirect_take) begin
      pc_next_d  = redirect_tgt;
      valid_d    = 1'b0;
      misalign_d = misalign_q | tgt_misaligned;
    end

    // A misaligned target never gets fetched: park in HOLD instead of issuing it.
    if (misalign_d && state_d == FETCH) state_d = HOLD;
  end

  // Output process: the request is a pure function of state, forced low in reset.
  always_comb begin
    imem_req  = !rst && (state_q != HOLD);
    imem_addr = (state_q == FETCH) ? pc_next_q : req_addr_q;
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[30];

  // State register process.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    if (rst) begin
      state_q    <= FETCH;
      pc_next_q  <= RESET_PC;
      req_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_next_q  <= pc_next_d;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level scoreboard checked every cycle,
// plus directed scenarios with literal expectations. Honours FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        fetch_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc),
    .op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds lw x1,0(x0); elsewhere a recognisable addi pattern.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2083;
    return (a << 8) | 32'h13;
  endfunction

  // Memory responder: acks after ack_delay cycles of a held request.
  int ack_delay = 0;
  int wait_cnt  = 0;
  always_comb imem_ack = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata = data_of(imem_addr);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: instr_valid never rose within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic go_to(input logic [31:0] target);
    wait_valid("go_to_wait", 40);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  // Scoreboard: what fetch should be doing, in terms of requests and delivered instructions.
  logic        m_valid = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_parked = 1'b0, m_misalign = 1'b0;
  logic [31:0] m_fetch = RESET_PC, m_out_addr = RESET_PC, m_instr = NOP, m_pc = RESET_PC;
  logic [31:0] hs_log[$];

  always @(negedge clk) begin : compare
    logic        exp_req, hs, redir, misal;
    logic [31:0] exp_addr, tgt;
    logic        n_valid, n_out, n_drop, n_parked, n_misalign;
    logic [31:0] n_fetch, n_out_addr, n_instr, n_pc;
    if (rst) begin
      check("req_in_reset", {31'b0, imem_req}, 32'h0);
      m_valid <= 1'b0; m_out <= 1'b0; m_drop <= 1'b0; m_parked <= 1'b0; m_misalign <= 1'b0;
      m_fetch <= RESET_PC; m_out_addr <= RESET_PC; m_instr <= NOP; m_pc <= RESET_PC;
    end else begin
      exp_req  = m_out || (!m_valid && !m_parked);
      exp_addr = m_out ? m_out_addr : m_fetch;
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, exp_addr);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("instr", instr, m_instr);
      check("pc", pc, m_pc);
      check("op", {25'b0, op}, {25'b0, m_instr[6:0]});
      check("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
      check("funct7", {31'b0, funct7}, {31'b0, m_instr[30]});
      check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_misalign});

`ifdef FETCH_ALIGN_CHECK_EN
      misal = (redirect_pc[1:0] != 2'b00);
      tgt   = redirect_pc;
`else
      misal = 1'b0;
      tgt   = {redirect_pc[31:2], 2'b00};
`endif
      redir = redirect && !m_parked;
      hs    = exp_req && imem_ack;
      n_valid = m_valid; n_out = m_out; n_drop = m_drop; n_parked = m_parked;
      n_misalign = m_misalign; n_fetch = m_fetch; n_out_addr = m_out_addr;
      n_instr = m_instr; n_pc = m_pc;

      if (hs) begin
        hs_log.push_back(exp_addr);
        n_out  = 1'b0;
        n_drop = 1'b0;
        if (!m_drop && !redir) begin
          n_valid = 1'b1;
          n_instr = data_of(exp_addr);
          n_pc    = exp_addr;
        end
      end else if (exp_req && !m_out) begin
        n_out      = 1'b1;
        n_out_addr = exp_addr;
      end
      if (m_valid && !stall && !redir) begin
        n_valid = 1'b0;
        n_fetch = m_pc + 32'd4;
      end
      if (redir) begin
        n_valid = 1'b0;
        n_fetch = tgt;
        if (exp_req && !imem_ack) n_drop = 1'b1;
        if (misal) begin
          n_misalign = 1'b1;
          n_parked   = 1'b1;
        end
      end

      m_valid <= n_valid; m_out <= n_out; m_drop <= n_drop; m_parked <= n_parked;
      m_misalign <= n_misalign; m_fetch <= n_fetch; m_out_addr <= n_out_addr;
      m_instr <= n_instr; m_pc <= n_pc;
    end
  end

  logic [31:0] exp_seq [3] = '{32'h0, 32'h4, 32'h8};

  initial begin
    repeat (3) tick();
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_misalign", {31'b0, fetch_misalign}, 32'h0);

    // Zero-latency memory straight out of reset; first word is lw.
    rst = 1'b0;
    tick();
    check("lw_valid", {31'b0, instr_valid}, 32'h1);
    check("lw_instr", instr, 32'h0000_2083);
    check("lw_op", {25'b0, op}, {25'b0, 7'b0000011});
    check("lw_funct3", {29'b0, funct3}, {29'b0, 3'b010});
    check("lw_funct7", {31'b0, funct7}, 32'h0);
    check("lw_pc", pc, 32'h0);
    repeat (5) tick();
    check("ack_count", {31'b0, (hs_log.size() >= 3)}, 32'h1);
    for (int i = 0; i < 3; i++)
      if (hs_log.size() > i) check("first_addrs", hs_log[i], exp_seq[i]);

    // Slow memory and a four-cycle stall in HOLD.
    go_to(32'h100);
    ack_delay = 3;
    stall     = 1'b1;
    wait_valid("slow_ack", 20);
    check("stall_pc_first", pc, 32'h100);
    check("stall_instr_first", instr, 32'h0001_0013);
    repeat (4) tick();
    check("stall_valid_held", {31'b0, instr_valid}, 32'h1);
    check("stall_pc_held", pc, 32'h100);
    check("stall_instr_held", instr, 32'h0001_0013);
    stall = 1'b0;

    // Redirect while waiting: the late data must be dropped.
    tick();
    tick();
    check("wait_addr", imem_addr, 32'h104);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("flush_addr", imem_addr, 32'h104);
    wait_valid("after_flush", 30);
    check("flush_pc", pc, 32'h40);
    check("flush_instr", instr, 32'h0000_4013);

    // Two redirects while a request is outstanding: the latest wins.
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    wait_valid("latest_wins", 30);
    check("latest_pc", pc, 32'h80);
    check("latest_instr", instr, 32'h0000_8013);

    // Redirect in the same cycle as an ack in FETCH.
    ack_delay = 0;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    wait_valid("redirect_ack", 10);
    check("redirect_ack_pc", pc, 32'h300);
    check("redirect_ack_instr", instr, 32'h0003_0013);

    // PC wrap at the top of the address space.
    go_to(32'hFFFF_FFFC);
    wait_valid("top_word", 10);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_instr", instr, 32'hFFFF_FC13);
    tick();
    check("wrap_req", {31'b0, imem_req}, 32'h1);
    check("wrap_addr", imem_addr, 32'h0);
    wait_valid("wrap_word", 10);
    check("wrap_pc", pc, 32'h0);

    // Misaligned redirect target.
    go_to(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("misalign_flag", {31'b0, fetch_misalign}, 32'h1);
      check("misalign_no_req", {31'b0, imem_req}, 32'h0);
      check("misalign_no_valid", {31'b0, instr_valid}, 32'h0);
      tick();
    end
`else
    wait_valid("aligned_down", 10);
    check("aligned_pc", pc, 32'h40);
    check("aligned_instr", instr, 32'h0000_4013);
`endif

    // Reset in the middle of a slow transaction.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ack_delay = 3;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_no_req", {31'b0, imem_req}, 32'h0);
    check("midrst_misalign", {31'b0, fetch_misalign}, 32'h0);
    rst = 1'b0;
    wait_valid("after_midrst", 20);
    check("midrst_pc", pc, RESET_PC);
    check("midrst_instr", instr, 32'h0000_2083);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
